// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester bridging a valid/ready command port onto APB.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // Encoding chosen so PSEL and PENABLE are single state bits, never decoded.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   done;
  logic   timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Abort on the TIMEOUT-th consecutive wait edge unless PREADY arrives.
  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY && !timeout_hit) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  // No timeout build: the abort term is a constant false.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    PSEL      = state[0];
    PENABLE   = state[1];
    cmd_ready = (state == IDLE) && !PRESET;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        accept = cmd_valid && cmd_ready;
        if (accept) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (PREADY || timeout_hit) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

  // PREADY wins over a same-edge timeout; an abort returns zero data with error.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done;
      if (done) begin
        rsp_err   <= PREADY ? PSLVERR : 1'b1;
        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard testbench for apb_master with a randomized APB slave model.
module tb_apb_master;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA = '0;
  logic              PREADY = 1'b0;
  logic              PSLVERR = 1'b0;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed { logic write; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
  typedef struct packed { int waits; logic [31:0] prdata; logic slverr; } plan_t;
  typedef struct packed { logic [31:0] rdata; logic err; int lat; } rsp_t;

  cmd_t  exp_cmd[$];
  plan_t plan_q[$];
  rsp_t  exp_rsp[$];
  int    acc_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a response is a function of the command and the slave's behaviour.
  function automatic rsp_t model(input cmd_t c, input plan_t p);
    rsp_t r;
`ifdef APB_MASTER_TIMEOUT_EN
    if (p.waits >= TIMEOUT) begin
      r.rdata = '0;
      r.err   = 1'b1;
      r.lat   = 1 + TIMEOUT;
      return r;
    end
`endif
    r.rdata = c.write ? 32'h0 : p.prdata;
    r.err   = p.slverr;
    r.lat   = 2 + p.waits;
    return r;
  endfunction

  // Slave model: waits p.waits ACCESS cycles, then completes; garbage everywhere else.
  initial begin
    plan_t cur_plan;
    int    wait_left;
    cur_plan  = '0;
    wait_left = 0;
    forever begin
      @(negedge PCLK);
      if (PSEL && !PENABLE) begin
        if (plan_q.size() != 0) cur_plan = plan_q.pop_front();
        else check("slave_plan_missing", plan_q.size(), 1);
        wait_left = cur_plan.waits;
        PREADY  = 1'($urandom);
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
      end else if (PSEL && PENABLE && wait_left == 0) begin
        PREADY  = 1'b1;
        PRDATA  = cur_plan.prdata;
        PSLVERR = cur_plan.slverr;
      end else begin
        if (PSEL && PENABLE) begin
          PREADY    = 1'b0;
          wait_left = wait_left - 1;
        end else begin
          PREADY = 1'($urandom);
        end
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
      end
    end
  end

  // Monitor / scoreboard, sampled 1ns after each rising edge.
  initial begin
    cmd_t cur;
    rsp_t e;
    cur = '0;
    forever begin
      @(posedge PCLK);
      #1;
      cyc++;
      if (PSEL) check("cmd_ready_busy", cmd_ready, 1'b0);
      if (PSEL && !PENABLE) begin
        acc_cyc = cyc;
        acc_log.push_back(cyc);
        if (exp_cmd.size() == 0) begin
          check("unexpected_setup", 1, 0);
        end else begin
          cur = exp_cmd.pop_front();
        end
      end
      if (PSEL) begin
        check("paddr", PADDR, cur.addr);
        check("pwrite", PWRITE, cur.write);
        check("pwdata", PWDATA, cur.wdata);
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", rsp_err, e.err);
          check("rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int waits, input logic [31:0] prd, input logic serr);
    int   n;
    cmd_t c;
    plan_t p;
    n = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 200) begin
      check("accept_timeout", 0, 1);
    end else begin
      c = '{write: w, addr: a, wdata: d};
      p = '{waits: waits, prdata: prd, slverr: serr};
      exp_cmd.push_back(c);
      plan_q.push_back(p);
      exp_rsp.push_back(model(c, p));
    end
  endtask

  task automatic drop();
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    check("drain", exp_rsp.size(), 0);
    @(negedge PCLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    // Reset state
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    PRESET = 1'b0;
    #1 check("post_rst_cmd_ready", cmd_ready, 1);

    // Directed cases
    issue(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0BAD_F00D, 1'b0);
    drop(); drain();
    issue(1'b0, 32'h24, 32'h0, 3, 32'h12345678, 1'b0);
    drop(); drain();
    issue(1'b0, 32'h28, 32'h0, 0, 32'hA5A5A5A5, 1'b1);
    drop(); drain();
    issue(1'b0, 32'h2C, 32'h0, 1, 32'h5A5A0001, 1'b0);
    drop(); drain();

    // Back-to-back with cmd_valid held
    base = acc_log.size();
    for (int k = 0; k < 4; k++)
      issue(1'($urandom), $urandom, $urandom, 0, $urandom, 1'b0);
    drop(); drain();
    check("b2b_count", acc_log.size() - base, 4);
    if (acc_log.size() - base == 4)
      for (int k = 1; k < 4; k++)
        check("b2b_spacing", acc_log[base + k] - acc_log[base + k - 1], 3);

    // Reset during an ACCESS wait state
    issue(1'b1, 32'h40, 32'hCAFEF00D, 6, 32'h0, 1'b0);
    drop();
    n = 0;
    while (!(PSEL && PENABLE) && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    check("reached_access", PSEL && PENABLE, 1);
    #2 PRESET = 1'b1;
    #1;
    check("midrst_psel", PSEL, 0);
    check("midrst_penable", PENABLE, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_pwrite", PWRITE, 0);
    check("midrst_paddr", PADDR, 0);
    check("midrst_pwdata", PWDATA, 0);
    check("midrst_rsp_rdata", rsp_rdata, 0);
    check("midrst_rsp_err", rsp_err, 0);
    exp_cmd.delete();
    plan_q.delete();
    exp_rsp.delete();
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    issue(1'b0, 32'h44, 32'h0, 2, 32'h600DD00D, 1'b0);
    drop(); drain();

`ifdef APB_MASTER_TIMEOUT_EN
    issue(1'b0, 32'h50, 32'h0, TIMEOUT + 2, 32'hFFFF0000, 1'b0);
    drop(); drain();
    issue(1'b0, 32'h54, 32'h0, TIMEOUT - 1, 32'h0F0F0F0F, 1'b1);
    drop(); drain();
`endif

    // Randomized traffic, random gaps (gap 0 keeps cmd_valid high)
    for (int t = 0; t < 150; t++) begin
      issue(1'($urandom), $urandom, $urandom, $urandom_range(0, TIMEOUT + 1),
            $urandom, ($urandom_range(0, 3) == 0));
      n = $urandom_range(0, 2);
      if (n != 0) begin
        drop();
        repeat (n - 1) @(negedge PCLK);
      end
    end
    drop(); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that bridges a simple valid/ready command port onto an APB bus. It is the initiator-side counterpart to the team's APB slaves. It drives PSEL/PENABLE/PADDR/PWRITE/PWDATA, honours PREADY wait states and returns read data and PSLVERR status on a one-cycle response strobe. It sits between local control logic (sequencers, register loaders) and the APB fabric.

## Interface
Parameters:
- ADDR_W, 32, address width of cmd_addr/PADDR
- DATA_W, 32, data width of cmd_wdata/PWDATA/PRDATA/rsp_rdata
- TIMEOUT, 16, wait-state limit in ACCESS cycles; must be ≥1; used only with APB_MASTER_TIMEOUT_EN

Ports:
- PCLK  in  1  bus clock; all logic on rising edge
- PRESET  in  1  asynchronous reset, active-high; one clock, no other reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_err  out  1  PSLVERR captured at completion, or timeout abort
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready / wait-state control
- PSLVERR  in  1  APB slave error

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS.
- IDLE:
  - PSEL = 0, PENABLE = 0, cmd_ready = 1.
  - On cmd_valid, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP:
  - PSEL = 1, PENABLE = 0, cmd_ready = 0.
  - Go unconditionally to ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1, cmd_ready = 0.
  - If PREADY = 0, stay in ACCESS.
  - If PREADY = 1, complete:
    - register rsp_rdata = PRDATA for reads, 0 for writes;
    - register rsp_err = PSLVERR;
    - assert rsp_valid for exactly one cycle;
    - go to IDLE.
- PSEL and PENABLE are decoded directly from the state register and are glitch-free.
- PADDR, PWRITE and PWDATA change only on command acceptance. They are held stable from SETUP through the completing ACCESS cycle and keep their last values in IDLE.
- rsp_rdata and rsp_err hold their values until the next completion. rsp_valid is the only pulse.
- Only one transfer is in flight at a time. No command is queued while busy. cmd_* inputs are don't-care while cmd_ready = 0.
- Reset values: state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata and rsp_err all 0; cmd_ready = 0 while PRESET is asserted and 1 after release.
- Reset mid-transfer: PSEL and PENABLE drop to 0 immediately (asynchronous), the transfer is abandoned and no rsp_valid is produced.
- Reads with PSLVERR = 1 still return PRDATA in rsp_rdata. The consumer must qualify the data with rsp_err.

## Timing
- Command accepted at edge N. SETUP occupies cycle N..N+1 and ACCESS starts after edge N+1.
- Zero-wait transfer:
  - PREADY = 1 is sampled at edge N+2;
  - rsp_valid is high during cycle N+2..N+3;
  - that cycle is back in IDLE, so cmd_ready = 1 and a new command can be accepted at edge N+3.
  - Minimum command-to-command spacing is therefore 3 cycles.
- Each PREADY = 0 cycle in ACCESS adds one cycle to latency.
- Response latency from acceptance edge to rsp_valid is 2 + W edges, where W is the number of wait cycles.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) counts consecutive ACCESS cycles with PREADY = 0. It clears on entry to ACCESS and on reset.
  - When the count reaches TIMEOUT with PREADY still 0, the transfer is aborted at that edge: go to IDLE with rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - PREADY = 1 on the same edge takes priority and the transfer completes normally.
- APB_MASTER_TIMEOUT_EN undefined:
  - No counter is instantiated and ACCESS waits indefinitely for PREADY.
  - rsp_err reflects PSLVERR only. TIMEOUT is unused.

## Test plan
- Zero-wait write:
  - Stimulus: cmd addr 0x10, wdata 0xDEADBEEF, PREADY tied 1.
  - Response: PSEL then PENABLE follow the SETUP/ACCESS sequence with PADDR = 0x10 and PWDATA = 0xDEADBEEF stable. rsp_valid pulses 2 edges after acceptance with rsp_rdata = 0, rsp_err = 0.
- Read with 3 wait states:
  - Stimulus: cmd addr 0x24, PREADY low for 3 ACCESS cycles, then high with PRDATA = 0x12345678.
  - Response: rsp_valid 5 edges after acceptance with rsp_rdata = 0x12345678. PADDR stays stable throughout.
- Slave error:
  - Stimulus: read with PSLVERR = 1 and PRDATA = 0xA5A5A5A5 at completion.
  - Response: rsp_err = 1, rsp_rdata = 0xA5A5A5A5. The next clean transfer returns rsp_err = 0.
- Back-to-back commands:
  - Stimulus: cmd_valid held high with 4 commands.
  - Response: acceptances exactly 3 edges apart. cmd_ready is low in SETUP and ACCESS. No overlapping PSEL phases are skipped.
- Reset mid-ACCESS:
  - Stimulus: assert PRESET during an ACCESS wait state.
  - Response: PSEL and PENABLE go 0 asynchronously, no rsp_valid, all outputs at reset values. A fresh transfer after release works.
- Timeout (macro defined, TIMEOUT = 4):
  - Stimulus: PREADY held 0.
  - Response: after 4 wait cycles, rsp_valid with rsp_err = 1 and rsp_rdata = 0, state back to IDLE.
  - Repeat with PREADY = 1 on the 4th edge: normal completion with rsp_err = PSLVERR.
